// File: rtl/serial_fir_framer.sv
`default_nettype none
// ============================================================================
//  Module      : serial_fir_framer
//  Description : Buffers parallel S(4,3) samples in a small FIFO and emits them
//                as fixed-length serial frames, LSB first, for a bit-serial FIR.
//                Each frame is NB_FRAME slots long. The sample bits occupy slots
//                0..NB_DATA_IN-1 and the remaining slots carry zero. If the FIFO
//                is empty when a frame is due, an all-zero frame is sent and an
//                underflow pulse is raised.
//
//  Ports       : clk            - single clock, rising edge
//                i_rst          - synchronous active-high reset
//                i_en           - frame advance enable (freezes framing when low)
//                i_sample       - parallel sample from upstream
//                i_valid        - i_sample valid
//                o_ready        - FIFO can accept a sample this cycle
//                o_data         - serial sample bit, LSB first
//                o_frame_start  - high during slot 0 of every frame
//                o_underflow    - one-cycle pulse: zero frame loaded (FIFO empty)
//                o_level        - current FIFO occupancy
//
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_fir_framer #(
    parameter int NB_DATA_IN = 4,
    parameter int NB_FRAME   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic [NB_DATA_IN-1:0]         i_sample,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_data,
    output logic                          o_frame_start,
    output logic                          o_underflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int c_CW  = (NB_FRAME > 1) ? $clog2(NB_FRAME) : 1;
    localparam int c_AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_LW  = $clog2(FIFO_DEPTH) + 1;
    localparam int c_PAD = NB_FRAME - NB_DATA_IN;

    localparam logic [c_CW-1:0] c_LAST_SLOT = c_CW'(NB_FRAME - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);
    localparam logic [c_LW-1:0] c_LVL_ONE   = c_LW'(1);
    localparam logic [c_LW-1:0] c_LVL_FULL  = c_LW'(FIFO_DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NB_DATA_IN-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wptr;
    logic [c_AW-1:0]       r_rptr;
    logic [c_LW-1:0]       r_level;

    logic [c_CW-1:0]       r_cnt;
    logic [NB_FRAME-1:0]   r_shift;
    logic                  r_underflow;

    // ------------------------------------------------------------------------
    // Handshake and frame-boundary decode. Everything is derived from the
    // registered occupancy, so a sample pushed on the same edge as a frame
    // load can never be bypassed into that frame.
    // ------------------------------------------------------------------------
    logic w_ready;
    logic w_push;
    logic w_last_slot;
    logic w_pop;
    logic w_underflow;

    assign w_ready     = (r_level < c_LVL_FULL);
    assign w_push      = i_valid && w_ready;
    assign w_last_slot = i_en && (r_cnt == c_LAST_SLOT);
    assign w_pop       = w_last_slot && (r_level != '0);
    assign w_underflow = w_last_slot && (r_level == '0);

    // ------------------------------------------------------------------------
    // Sample storage. Contents need no reset: occupancy and pointers define
    // which entries are meaningful.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push && !i_rst) begin
            r_mem[r_wptr] <= i_sample;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy. Pointers are exactly c_AW bits wide, so
    // they wrap modulo FIFO_DEPTH naturally (depth is a power of two).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Frame counter and output shift register. Reset parks the counter on the
    // last slot so the first enabled edge afterwards opens a fresh frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_cnt       <= c_LAST_SLOT;
            r_shift     <= '0;
            r_underflow <= 1'b0;
        end else begin
            // w_last_slot already includes i_en, so this stays low while
            // the framer is frozen.
            r_underflow <= w_underflow;
            if (i_en) begin
                if (r_cnt == c_LAST_SLOT) begin
                    r_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= {{c_PAD{1'b0}}, r_mem[r_rptr]};
                    end else begin
                        r_shift <= '0;
                    end
                end else begin
                    r_cnt   <= r_cnt + c_CNT_ONE;
                    r_shift <= {1'b0, r_shift[NB_FRAME-1:1]};
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all taken straight from registers)
    // ------------------------------------------------------------------------
    assign o_ready       = w_ready;
    assign o_data        = r_shift[0];
    assign o_frame_start = (r_cnt == '0);
    assign o_underflow   = r_underflow;
    assign o_level       = r_level;

endmodule
`default_nettype wire

// File: tb/tb_serial_fir_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_fir_framer
//  Description : Self-checking bench for serial_fir_framer. A queue of
//                accepted samples serves as the scoreboard: samples are pushed
//                when driven and accepted, popped when a frame is due, and
//                the serial output of each frame is compared slot by slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_fir_framer;

    localparam int NB_DATA_IN = 4;
    localparam int NB_FRAME   = 8;
    localparam int FIFO_DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  i_rst;
    logic                  i_en;
    logic [NB_DATA_IN-1:0] i_sample;
    logic                  i_valid;
    logic                  o_ready;
    logic                  o_data;
    logic                  o_frame_start;
    logic                  o_underflow;
    logic [2:0]            o_level;

    always #5 clk = ~clk;

    serial_fir_framer #(
        .NB_DATA_IN (NB_DATA_IN),
        .NB_FRAME   (NB_FRAME),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_en          (i_en),
        .i_sample      (i_sample),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_data        (o_data),
        .o_frame_start (o_frame_start),
        .o_underflow   (o_underflow),
        .o_level       (o_level)
    );

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scoreboard / reference state
    // ------------------------------------------------------------------------
    logic [NB_DATA_IN-1:0] m_q[$];      // accepted, not yet framed samples
    int                    m_cnt;       // slot currently on the outputs
    logic [NB_DATA_IN-1:0] m_frame;     // sample carried by current frame
    logic                  m_uf;        // underflow pulse expected this cycle

    task automatic compare_outputs(input string tag);
        logic exp_bit;
        exp_bit = (m_cnt < NB_DATA_IN) ? m_frame[m_cnt] : 1'b0;
        check_val({tag, "_level"}, 32'(o_level), 32'(m_q.size()));
        check_val({tag, "_ready"}, 32'(o_ready), 32'(m_q.size() < FIFO_DEPTH));
        check_val({tag, "_fstart"}, 32'(o_frame_start), 32'(m_cnt == 0));
        check_val({tag, "_data"}, 32'(o_data), 32'(exp_bit));
        check_val({tag, "_uflow"}, 32'(o_underflow), 32'(m_uf));
    endtask

    // One clock edge with the given inputs; scoreboard updated alongside.
    task automatic step(input logic en, input logic valid, input logic [NB_DATA_IN-1:0] s);
        logic push;
        logic pop_slot;
        i_rst    = 1'b0;
        i_en     = en;
        i_valid  = valid;
        i_sample = s;
        push     = valid && (m_q.size() < FIFO_DEPTH);
        pop_slot = en && (m_cnt == NB_FRAME - 1);
        m_uf     = 1'b0;
        if (pop_slot) begin
            if (m_q.size() > 0) begin
                m_frame = m_q.pop_front();
            end else begin
                m_frame = '0;
                m_uf    = 1'b1;
            end
        end
        if (push) m_q.push_back(s);
        if (en) m_cnt = (m_cnt + 1) % NB_FRAME;
        @(posedge clk);
        #1;
        compare_outputs("step");
    endtask

    task automatic do_reset(input logic en, input logic valid);
        i_rst    = 1'b1;
        i_en     = en;
        i_valid  = valid;
        i_sample = 4'hF;
        m_q.delete();
        m_cnt   = NB_FRAME - 1;
        m_frame = '0;
        m_uf    = 1'b0;
        @(posedge clk);
        #1;
        compare_outputs("reset");
        i_rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [7:0] seq;
        logic [7:0] fs_seq;
        logic [3:0] nib;
        int         n_uf;
        int         n_ones;

        i_rst = 1'b1; i_en = 1'b0; i_valid = 1'b0; i_sample = '0;
        m_cnt = NB_FRAME - 1; m_frame = '0; m_uf = 1'b0;

        // Reset state
        do_reset(1'b0, 1'b0);
        check_val("rst_level", 32'(o_level), 32'd0);
        check_val("rst_ready", 32'(o_ready), 32'd1);

        // Single sample -0.625 serialised LSB first
        step(1'b0, 1'b1, 4'b1011);
        for (int i = 0; i < NB_FRAME; i++) begin
            step(1'b1, 1'b0, 4'h0);
            seq[i]    = o_data;
            fs_seq[i] = o_frame_start;
        end
        check_val("one_sample_bits", 32'(seq), 32'h0B);
        check_val("one_sample_fstart", 32'(fs_seq), 32'h01);
        step(1'b1, 1'b0, 4'h0);
        check_val("one_sample_next_uflow", 32'(o_underflow), 32'd1);

        // Fill to full while frozen, fifth push refused, then drain in order
        do_reset(1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, 4'(k));
        check_val("full_level", 32'(o_level), 32'd4);
        check_val("full_ready", 32'(o_ready), 32'd0);
        for (int f = 0; f < 4; f++) begin
            for (int sl = 0; sl < NB_FRAME; sl++) begin
                step(1'b1, 1'b0, 4'h0);
                if (sl < NB_DATA_IN) nib[sl] = o_data;
            end
            check_val("drain_order", 32'(nib), 32'(f + 1));
        end
        step(1'b1, 1'b0, 4'h0);
        check_val("drain_then_uflow", 32'(o_underflow), 32'd1);

        // Free-running with nothing pushed
        do_reset(1'b0, 1'b0);
        n_uf = 0; n_ones = 0;
        for (int i = 0; i < 3 * NB_FRAME; i++) begin
            step(1'b1, 1'b0, 4'h0);
            n_uf   += int'(o_underflow);
            n_ones += int'(o_data);
        end
        check_val("idle_uflow_count", 32'(n_uf), 32'd3);
        check_val("idle_data_ones", 32'(n_ones), 32'd0);

        // Push coincident with pop at two entries
        do_reset(1'b0, 1'b0);
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'h9);
        step(1'b1, 1'b1, 4'h6);
        while (m_cnt != NB_FRAME - 1) step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'hC);
        check_val("pushpop_level", 32'(o_level), 32'd2);
        nib[0] = o_data;
        for (int sl = 1; sl < NB_DATA_IN; sl++) begin
            step(1'b1, 1'b0, 4'h0);
            nib[sl] = o_data;
        end
        check_val("pushpop_oldest", 32'(nib), 32'h9);

        // Push into empty FIFO on the frame-load edge is not bypassed
        do_reset(1'b0, 1'b0);
        step(1'b1, 1'b1, 4'h5);
        check_val("nobypass_uflow", 32'(o_underflow), 32'd1);
        check_val("nobypass_level", 32'(o_level), 32'd1);

        // Mid-frame reset with entries buffered
        do_reset(1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h3);
        step(1'b0, 1'b1, 4'h5);
        step(1'b0, 1'b1, 4'hA);
        step(1'b0, 1'b1, 4'hE);
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);
        check_val("midrst_pre_level", 32'(o_level), 32'd3);
        do_reset(1'b1, 1'b1);
        check_val("midrst_level", 32'(o_level), 32'd0);
        check_val("midrst_data", 32'(o_data), 32'd0);
        step(1'b1, 1'b0, 4'h0);
        check_val("midrst_first_uflow", 32'(o_underflow), 32'd1);
        check_val("midrst_first_fstart", 32'(o_frame_start), 32'd1);

        // Enable toggling stretches but does not alter the bit stream
        do_reset(1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h7);
        step(1'b1, 1'b0, 4'h0);
        nib[0] = o_data;
        step(1'b1, 1'b0, 4'h0); nib[1] = o_data;
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0); nib[2] = o_data;
        step(1'b1, 1'b0, 4'h0); nib[3] = o_data;
        check_val("entoggle_bits", 32'(nib), 32'h7);

        // Random traffic against the scoreboard
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), 4'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
